// File: rtl/adc_multi_rx.sv
// Multi-channel serial ADC receiver: drives a shared cs/sclk pair and captures
// N_CH MSB-first data lines into parallel words, one frame at a time.
module adc_multi_rx #(
  parameter int N_CH  = 2,
  parameter int DW    = 12,
  parameter int LEAD  = 4,
  parameter int DIV   = 2,
  parameter int QUIET = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic [N_CH-1:0]      sdata,
  output logic                 cs,
  output logic                 sclk,
  output logic [N_CH*DW-1:0]   data_out,
  output logic                 data_valid,
  output logic [N_CH-1:0]      lead_err,
  output logic                 busy
);

  localparam int F  = LEAD + DW;
  localparam int HW = $clog2(2*DIV + 1);
  localparam int BW = $clog2(F + 1);
  localparam int GW = $clog2(QUIET + 1);

  localparam logic [HW-1:0] H_SETUP_LAST = HW'(DIV - 1);
  localparam logic [HW-1:0] H_LOW        = HW'(DIV);
  localparam logic [HW-1:0] H_BIT_LAST   = HW'(2*DIV - 1);
  localparam logic [BW-1:0] B_LAST       = BW'(F - 1);
  localparam logic [GW-1:0] G_LAST       = GW'(QUIET - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   hcnt_reg, hcnt_next;
  logic [BW-1:0]   bcnt_reg, bcnt_next;
  logic [GW-1:0]   gcnt_reg, gcnt_next;
  logic            cs_reg, cs_next;
  logic            sclk_reg, sclk_next;
  logic            data_valid_reg;
  logic            sample_en;

  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    bcnt_next  = bcnt_reg;
    gcnt_next  = gcnt_reg;
    case (state_reg)
      IDLE: begin
        if (start || cont) begin
          state_next = SETUP;
          hcnt_next  = '0;
        end
      end
      SETUP: begin
        if (hcnt_reg == H_SETUP_LAST) begin
          state_next = SHIFT;
          hcnt_next  = '0;
          bcnt_next  = '0;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt_reg == H_BIT_LAST) begin
          hcnt_next = '0;
          if (bcnt_reg == B_LAST) begin
            state_next = DONE;
          end else begin
            bcnt_next = bcnt_reg + 1'b1;
          end
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = GAP;
        gcnt_next  = '0;
      end
      GAP: begin
        if (gcnt_reg == G_LAST) begin
          state_next = cont ? SETUP : IDLE;
          hcnt_next  = '0;
        end else begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line levels are decoded from the upcoming state so the registered pins line up with it.
    cs_next   = !(state_next == SETUP || state_next == SHIFT);
    sclk_next = !(state_next == SHIFT && hcnt_next < H_LOW);
    sample_en = (state_reg == SHIFT) && !sclk_reg && sclk_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      hcnt_reg       <= '0;
      bcnt_reg       <= '0;
      gcnt_reg       <= '0;
      cs_reg         <= 1'b1;
      sclk_reg       <= 1'b1;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hcnt_reg       <= hcnt_next;
      bcnt_reg       <= bcnt_next;
      gcnt_reg       <= gcnt_next;
      cs_reg         <= cs_next;
      sclk_reg       <= sclk_next;
      data_valid_reg <= (state_next == DONE);
    end
  end

  // One capture shift register and one published word per data line.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [F-1:0]  shreg_reg;
    logic [DW-1:0] data_reg;
    logic          lead_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shreg_reg <= '0;
        data_reg  <= '0;
        lead_reg  <= 1'b0;
      end else begin
        if (sample_en) begin
          shreg_reg <= {shreg_reg[F-2:0], sdata[gi]};
        end
        if (state_next == DONE) begin
          data_reg <= shreg_reg[DW-1:0];
          lead_reg <= |shreg_reg[F-1 -: LEAD];
        end
      end
    end

    assign data_out[gi*DW +: DW] = data_reg;
    assign lead_err[gi]          = lead_reg;
  end

  assign cs         = cs_reg;
  assign sclk       = sclk_reg;
  assign data_valid = data_valid_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_adc_multi_rx.sv
// Bench for adc_multi_rx: serial converter models drive sdata on sclk falls and
// predict every published frame; two instances cover the 2-ch/DIV=2 and 1-ch/DIV=1 cases.
module tb_adc_multi_rx;
  localparam int DW      = 12;
  localparam int LEAD    = 4;
  localparam int F       = LEAD + DW;
  localparam int QUIET   = 4;
  localparam int NA      = 2;
  localparam int DIVA    = 2;
  localparam int NB      = 1;
  localparam int DIVB    = 1;
  localparam int CSLOW_A = DIVA + 2*DIVA*F;
  localparam int CSLOW_B = DIVB + 2*DIVB*F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_a = 1'b0, cont_a = 1'b0;
  logic [NA-1:0]     sdata_a = '0;
  logic              cs_a, sclk_a, data_valid_a, busy_a;
  logic [NA*DW-1:0]  data_out_a;
  logic [NA-1:0]     lead_err_a;

  logic              start_b = 1'b0, cont_b = 1'b0;
  logic [NB-1:0]     sdata_b = '0;
  logic              cs_b, sclk_b, data_valid_b, busy_b;
  logic [NB*DW-1:0]  data_out_b;
  logic [NB-1:0]     lead_err_b;

  adc_multi_rx #(.N_CH(NA), .DW(DW), .LEAD(LEAD), .DIV(DIVA), .QUIET(QUIET)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .sdata(sdata_a),
    .cs(cs_a), .sclk(sclk_a), .data_out(data_out_a), .data_valid(data_valid_a),
    .lead_err(lead_err_a), .busy(busy_a));

  adc_multi_rx #(.N_CH(NB), .DW(DW), .LEAD(LEAD), .DIV(DIVB), .QUIET(QUIET)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .sdata(sdata_b),
    .cs(cs_b), .sclk(sclk_b), .data_out(data_out_b), .data_valid(data_valid_b),
    .lead_err(lead_err_b), .busy(busy_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Converter model A: a frame word per channel, shifted out MSB first on each sclk fall.
  logic [F-1:0]     tx_a [NA];
  logic [F-1:0]     cur_a [NA];
  int               bit_a = 0, rises_a = 0, cslow_a = 0;
  int               last_len_a = 0, last_rises_a = 0, dv_cnt_a = 0;
  logic             cs_prev_a = 1'b1, sclk_prev_a = 1'b1;
  logic [NA*DW-1:0] hold_a = '0;
  logic [NA-1:0]    hold_l_a = '0;
  logic [NA*DW-1:0] expq_a [$];
  logic [NA-1:0]    expl_a [$];

  always @(negedge clk) begin
    logic [NA*DW-1:0] ed;
    logic [NA-1:0]    el;
    if (rst) begin
      bit_a = 0; rises_a = 0; cslow_a = 0;
      cs_prev_a = 1'b1; sclk_prev_a = 1'b1;
      hold_a = '0; hold_l_a = '0;
      expq_a.delete(); expl_a.delete();
      chk("rst_lines_a", {cs_a, sclk_a, data_valid_a, busy_a}, 4'b1100);
      chk("rst_data_a", data_out_a, 0);
    end else begin
      if (cs_prev_a && !cs_a) begin
        for (int c = 0; c < NA; c++) cur_a[c] = tx_a[c];
        bit_a = 0; rises_a = 0; cslow_a = 0;
      end
      if (!cs_a) begin
        cslow_a++;
        chk("busy_in_frame_a", busy_a, 1'b1);
        if (sclk_prev_a && !sclk_a && bit_a < F) begin
          for (int c = 0; c < NA; c++) sdata_a[c] = cur_a[c][F-1-bit_a];
          bit_a++;
        end
        if (!sclk_prev_a && sclk_a) rises_a++;
      end
      if (!cs_prev_a && cs_a) begin
        last_len_a = cslow_a;
        last_rises_a = rises_a;
        chk("cs_low_len_a", cslow_a, CSLOW_A);
        chk("sclk_rises_a", rises_a, F);
        for (int c = 0; c < NA; c++) begin
          ed[c*DW +: DW] = cur_a[c][DW-1:0];
          el[c] = |cur_a[c][F-1 -: LEAD];
        end
        expq_a.push_back(ed);
        expl_a.push_back(el);
      end
      if (data_valid_a) begin
        dv_cnt_a++;
        $display("A frame %0d: data_out=%h lead_err=%b", dv_cnt_a, data_out_a, lead_err_a);
        if (expq_a.size() == 0) begin
          chk("dv_unexpected_a", data_valid_a, 1'b0);
        end else begin
          hold_a = expq_a.pop_front();
          hold_l_a = expl_a.pop_front();
        end
      end
      chk("data_out_a", data_out_a, hold_a);
      chk("lead_err_a", lead_err_a, hold_l_a);
      if (!busy_a) chk("idle_lines_a", {cs_a, sclk_a}, 2'b11);
      cs_prev_a = cs_a;
      sclk_prev_a = sclk_a;
    end
  end

  // Converter model B: single line, same rules.
  logic [F-1:0]     tx_b = '0;
  logic [F-1:0]     cur_b = '0;
  int               bit_b = 0, rises_b = 0, cslow_b = 0;
  int               last_len_b = 0, last_rises_b = 0, dv_cnt_b = 0;
  logic             cs_prev_b = 1'b1, sclk_prev_b = 1'b1;
  logic [NB*DW-1:0] hold_b = '0;
  logic [NB-1:0]    hold_l_b = '0;
  logic [NB*DW-1:0] expq_b [$];
  logic [NB-1:0]    expl_b [$];

  always @(negedge clk) begin
    if (rst) begin
      bit_b = 0; rises_b = 0; cslow_b = 0;
      cs_prev_b = 1'b1; sclk_prev_b = 1'b1;
      hold_b = '0; hold_l_b = '0;
      expq_b.delete(); expl_b.delete();
      chk("rst_lines_b", {cs_b, sclk_b, data_valid_b, busy_b}, 4'b1100);
      chk("rst_data_b", data_out_b, 0);
    end else begin
      if (cs_prev_b && !cs_b) begin
        cur_b = tx_b;
        bit_b = 0; rises_b = 0; cslow_b = 0;
      end
      if (!cs_b) begin
        cslow_b++;
        if (sclk_prev_b && !sclk_b && bit_b < F) begin
          sdata_b[0] = cur_b[F-1-bit_b];
          bit_b++;
        end
        if (!sclk_prev_b && sclk_b) rises_b++;
      end
      if (!cs_prev_b && cs_b) begin
        last_len_b = cslow_b;
        last_rises_b = rises_b;
        chk("cs_low_len_b", cslow_b, CSLOW_B);
        chk("sclk_rises_b", rises_b, F);
        expq_b.push_back(cur_b[DW-1:0]);
        expl_b.push_back(|cur_b[F-1 -: LEAD]);
      end
      if (data_valid_b) begin
        dv_cnt_b++;
        $display("B frame %0d: data_out=%h lead_err=%b", dv_cnt_b, data_out_b, lead_err_b);
        if (expq_b.size() == 0) begin
          chk("dv_unexpected_b", data_valid_b, 1'b0);
        end else begin
          hold_b = expq_b.pop_front();
          hold_l_b = expl_b.pop_front();
        end
      end
      chk("data_out_b", data_out_b, hold_b);
      chk("lead_err_b", lead_err_b, hold_l_b);
      if (!busy_b) chk("idle_lines_b", {cs_b, sclk_b}, 2'b11);
      cs_prev_b = cs_b;
      sclk_prev_b = sclk_b;
    end
  end

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts negedges until the selected data_valid is seen; an expired budget is a failure.
  task automatic wait_dv(input bit sel_b, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel_b ? data_valid_b : data_valid_a) && n < limit);
    chk(sel_b ? "wait_dv_b" : "wait_dv_a", sel_b ? data_valid_b : data_valid_a, 1'b1);
  endtask

  initial begin
    int n, d0;
    tx_a[0] = '0;
    tx_a[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_data_a", data_out_a, 24'h000000);
    chk("reset_cs_sclk_a", {cs_a, sclk_a}, 2'b11);
    chk("reset_busy_dv_a", {busy_a, data_valid_a}, 2'b00);
    @(posedge clk); #2 rst = 1'b0;

    // single frame from a start pulse
    tx_a[0] = 16'h0A5C; tx_a[1] = 16'h03F1;
    d0 = dv_cnt_a;
    pulse_start(1'b0);
    wait_dv(1'b0, 300, n);
    repeat (20) @(negedge clk); #1;
    chk("t1_data", data_out_a, 24'h3F1A5C);
    chk("t1_lead", lead_err_a, 2'b00);
    chk("t1_cs_low", last_len_a, 66);
    chk("t1_rises", last_rises_a, 16);
    chk("t1_dv_count", dv_cnt_a - d0, 1);
    chk("t1_idle", busy_a, 1'b0);

    // nonzero leading bit on ch1
    tx_a[1] = 16'h83F1;
    pulse_start(1'b0);
    wait_dv(1'b0, 300, n);
    chk("t2_ch1", data_out_a[23:12], 12'h3F1);
    chk("t2_lead", lead_err_a, 2'b10);
    repeat (10) @(negedge clk);

    // continuous mode, then cont dropped mid-frame
    d0 = dv_cnt_a;
    tx_a[0] = 16'h0FFF; tx_a[1] = 16'h0000;
    @(negedge clk); cont_a = 1'b1;
    wait_dv(1'b0, 300, n);
    tx_a[0] = 16'h0123; tx_a[1] = 16'h0456;
    wait_dv(1'b0, 300, n);
    chk("t3_interval1", n, 71);
    chk("t3_data2", data_out_a, 24'h456123);
    tx_a[0] = 16'hF000; tx_a[1] = 16'h1ABC;
    wait_dv(1'b0, 300, n);
    chk("t3_interval2", n, 71);
    chk("t3_data3", data_out_a, 24'hABC000);
    chk("t3_lead3", lead_err_a, 2'b11);
    tx_a[0] = 16'h0777; tx_a[1] = 16'h0888;
    repeat (30) @(negedge clk);
    cont_a = 1'b0;
    wait_dv(1'b0, 300, n);
    chk("t3_last_frame_at", n, 41);
    chk("t3_data4", data_out_a, 24'h888777);
    repeat (150) @(negedge clk); #1;
    chk("t3_dv_count", dv_cnt_a - d0, 4);
    chk("t3_idle", busy_a, 1'b0);

    // start during SHIFT is ignored
    d0 = dv_cnt_a;
    tx_a[0] = 16'h0321; tx_a[1] = 16'h0654;
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    pulse_start(1'b0);
    wait_dv(1'b0, 300, n);
    chk("t4_data", data_out_a, 24'h654321);
    repeat (150) @(negedge clk); #1;
    chk("t4_dv_count", dv_cnt_a - d0, 1);
    chk("t4_idle", busy_a, 1'b0);

    // reset at bit 7 of a frame
    tx_a[0] = 16'h0FED; tx_a[1] = 16'h0CBA;
    pulse_start(1'b0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(cs_a == 1'b0 && rises_a >= 7) && n < 300);
    chk("t5_reach_bit7", rises_a >= 7, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_cs_sclk", {cs_a, sclk_a}, 2'b11);
    chk("t5_data_cleared", data_out_a, 24'h000000);
    chk("t5_dv_busy", {data_valid_a, busy_a}, 2'b00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    d0 = dv_cnt_a;
    repeat (100) @(negedge clk); #1;
    chk("t5_no_frame", dv_cnt_a - d0, 0);
    chk("t5_idle", busy_a, 1'b0);
    pulse_start(1'b0);
    wait_dv(1'b0, 300, n);
    chk("t5_data", data_out_a, 24'hCBAFED);

    // single channel, DIV=1
    tx_b = 16'h0ABC;
    pulse_start(1'b1);
    wait_dv(1'b1, 300, n);
    chk("t6_data", data_out_b, 12'hABC);
    repeat (2) @(negedge clk); #1;
    chk("t6_cs_low", last_len_b, 33);
    chk("t6_rises", last_rises_b, 16);
    tx_b = 16'h5123;
    repeat (10) @(negedge clk);
    pulse_start(1'b1);
    wait_dv(1'b1, 300, n);
    chk("t6_data2", data_out_b, 12'h123);
    chk("t6_lead2", lead_err_b, 1'b1);
    repeat (10) @(negedge clk); #1;
    chk("t6_dv_count", dv_cnt_b, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
